// File: rtl/morse_tone_gen.sv
// -----------------------------------------------------------------------------
// morse_tone_gen
//   N-channel square-wave tone generator for the Morse translator audio path.
//   Each channel toggles its speaker pin every half[i] clocks while its gate is
//   high. When the gate drops during a high phase, that phase runs to its end
//   (drain) so a tone never stops mid-high-phase. Half-periods can be changed
//   at runtime; a running channel picks up a new value at its next reload.
//
//   Optional feature macro: MORSE_MIX_OUT_EN
//     defined   -> first-order sigma-delta mix of all tones onto 'mix'
//     undefined -> 'mix' tied low, no accumulator
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high, overrides everything
//   gate      per-channel tone request (level)
//   cfg_we    half-period write strobe (one-cycle pulse)
//   cfg_ch    channel index for the write
//   cfg_half  new half-period in clk cycles (must be >= 2)
//   tone      registered square-wave outputs
//   active    registered "channel running or draining" flags
//   cfg_err   one-cycle pulse after a rejected write
//   mix       mixed PWM output (see macro above)
// -----------------------------------------------------------------------------
module morse_tone_gen #(
  parameter int                        NUM_CH   = 2,
  parameter int                        CNT_W    = 18,
  parameter logic [NUM_CH*CNT_W-1:0]   DEF_HALF = {18'd255102, 18'd113636},
  localparam int                       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] gate,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] tone,
  output logic [NUM_CH-1:0] active,
  output logic              cfg_err,
  output logic              mix
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  half_q  [NUM_CH];
  logic [NUM_CH-1:0] tone_d;
  logic [NUM_CH-1:0] active_d;
  logic              cfg_ok;

  // Channel index is widened by one bit so the range check stays meaningful
  // when NUM_CH is a power of two.
  assign cfg_ok = cfg_we
               && ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH))
               && (cfg_half >= CNT_W'(2));

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  // NOTE: the half-period array is deliberately reset: it is a handful of
  // flops, not a RAM, and must come back to the default tones after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) half_q[i] <= DEF_HALF[i*CNT_W +: CNT_W];
      cfg_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (cfg_ok && (cfg_ch == CH_W'(i))) half_q[i] <= cfg_half;
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      tone   <= '0;
      active <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      tone   <= tone_d;
      active <= active_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        IDLE:  if (gate[i]) state_d[i] = RUN;
        // A high phase that still has cycles left is drained; a high phase
        // ending on this very edge or any low phase stops immediately.
        RUN:   if (!gate[i]) state_d[i] = (tone[i] && cnt_q[i] != '0) ? DRAIN : IDLE;
        DRAIN: begin
          if (gate[i])               state_d[i] = RUN;
          else if (cnt_q[i] == '0)   state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel FSM: counter / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      tone_d[i]   = tone[i];
      active_d[i] = (state_d[i] != IDLE);
      unique case (state_q[i])
        IDLE: begin
          if (gate[i]) begin
            cnt_d[i]  = half_q[i] - CNT_W'(1);
            tone_d[i] = 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (state_d[i] == IDLE) begin
            cnt_d[i]  = '0;
            tone_d[i] = 1'b0;
          end else if (cnt_q[i] == '0) begin
            // Reload reads the current register, so a write landing on this
            // same edge only takes effect at the following reload.
            cnt_d[i]  = half_q[i] - CNT_W'(1);
            tone_d[i] = ~tone[i];
          end else begin
            cnt_d[i]  = cnt_q[i] - CNT_W'(1);
          end
        end
        default: begin
          cnt_d[i]  = '0;
          tone_d[i] = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional sigma-delta mixer
  // ---------------------------------------------------------------------------
`ifdef MORSE_MIX_OUT_EN
  // acc < NUM_CH and popcount <= NUM_CH, so the sum fits in CH_W+1 bits.
  logic [CH_W:0] acc_q;
  logic [CH_W:0] mix_sum;

  always_comb begin
    mix_sum = acc_q;
    for (int i = 0; i < NUM_CH; i++) mix_sum = mix_sum + (CH_W+1)'(tone[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      mix   <= 1'b0;
    end else if (mix_sum >= (CH_W+1)'(NUM_CH)) begin
      acc_q <= mix_sum - (CH_W+1)'(NUM_CH);
      mix   <= 1'b1;
    end else begin
      acc_q <= mix_sum;
      mix   <= 1'b0;
    end
  end
`else
  assign mix = 1'b0;
`endif

endmodule
